text_fetch_pipeline: RTL and testbench
======================================

# text_fetch_pipeline

Pixel-rate fetch stage that sits between the VGA timing generator and the colour mapper in the HDMI text controller. For each screen position it locates the 80x30 character cell, reads the glyph word from VRAM, reads the glyph row from the font ROM and resolves foreground and background colours from the palette registers. It then delivers `inv_bit`, `cmd`, `font_line` and the delayed pixel coordinate and sync signals to the colour mapper, all aligned to a fixed 4-cycle latency.

## Interface
- `COLS`, 80: text columns (must be even)
- `ROWS`, 30: text rows
- `pixel_clk`  in  1  pixel clock; the only clock
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `pixel_clk`
- `drawX`  in  10  current pixel column from the timing generator
- `drawY`  in  10  current pixel row from the timing generator
- `hs`, `vs`  in  1  syncs, active-low
- `vde`  in  1  active-video enable
- `palette`  in  256  8 palette words; word k is `palette[32k+31:32k]`
- `vram_addr`  out  11  VRAM word address (registered; BRAM has 1-cycle read latency)
- `vram_rdata`  in  32  VRAM read data; two characters per word
- `font_addr`  out  11  font ROM address {code[6:0], glyph_row[3:0]} (registered; ROM has 1-cycle latency)
- `font_data`  in  8  font ROM row; bit 7 is the leftmost pixel
- `drawX_out`, `drawY_out`  out  10  delayed coordinates
- `hs_out`, `vs_out`, `vde_out`  out  1  delayed syncs and enable
- `inv_bit`  out  1  inverse flag for the cell
- `cmd`  out  32  [24:13] fg RGB444, [12:1] bg RGB444, other bits 0
- `font_line`  out  8  glyph row for the cell

## Operation
- Character halfword layout: [15] inv, [14:8] code, [7:4] fg index, [3:0] bg index. The low halfword holds the even column; the high halfword holds the odd column.
- Palette colour i lives in word i>>1. For i[0]=0 it is bits [12:1]; for i[0]=1 it is bits [24:13].
- Stage A (edge E0, samples inputs):
  - col = drawX[9:3]; row = drawY[8:4].
  - idx = row*80 + col, 12-bit unsigned, implemented as (row<<6)+(row<<4)+col; maximum value 2399.
  - `vram_addr` <= idx[11:1]; half_A <= drawX[3].
  - If drawX ≥ 640 or drawY ≥ 480, `vram_addr` <= 0.
  - Carry drawX, drawY[3:0], hs, vs and vde forward.
- Stage B (E2): select the halfword by half_A (delayed one cycle to align with `vram_rdata`).
  - `font_addr` <= {code, drawY[3:0]}.
  - Register inv, fg colour and bg colour from `palette`.
- Stage C (E3): hold inv, colours and side-band one more cycle while the font ROM reads.
- Output (E4): register `font_line`, `inv_bit`, `cmd`, coordinates and syncs.
  - If the delayed vde is 0, force `font_line`=0, `inv_bit`=0 and `cmd`=0.
- `palette` is sampled at stage B only. A palette change mid-frame affects pixels whose stage B occurs after the change.
- No stalls and no handshake: the pipeline advances every cycle.

## Timing
- Latency is exactly 4 `pixel_clk` cycles from inputs sampled at E0 to all outputs valid after E4. Every output carries the same delay.
- Throughput is 1 pixel per cycle. Consecutive pixels in one cell issue repeated identical reads.
- Reset values:
  - All data outputs, `vram_addr` and `font_addr` = 0.
  - `vde_out` = 0.
  - `hs_out` = `vs_out` = 1 (inactive).
  - All internal pipeline registers are cleared.
- Reset mid-frame flushes the pipeline; nothing from before reset reaches the outputs. The first post-reset input reaches the outputs 4 cycles after reset deasserts.
- Wrap-around: drawX 799 to 0 and drawY 524 to 0 require no special handling. Out-of-range positions fetch address 0 and are blanked by vde.

## Test plan
- Cell 0:
  - Setup: word 0 = 0x0000_4121; palette word 0 = 0x0123_4000 (colour1 = 0x091A); palette word 1 = 0x0000_0ABC (colour2 = 0x55E); drawX=0, drawY=3, vde=1.
  - Required: `vram_addr`=0 after E0; `font_addr`=0x413 after E2; after E4 `inv_bit`=0, `cmd`[24:13]=0x55E, `cmd`[12:1]=0x091A, `font_line`=ROM[0x413].
- Odd cell: drawX=8, drawY=16 -> `vram_addr`=40 and the high halfword is selected. With word 40 = 0xC2F0_0000: `inv_bit`=1, code=0x42, fg=colour 15 from palette word 7 [24:13], bg=colour 0.
- Last cell: drawX=639, drawY=479 -> `vram_addr`=1199, high halfword, `font_addr` row field = 0xF.
- Blanking: vde=0 for 10 cycles with non-zero VRAM contents -> 4 cycles later `font_line`=0, `cmd`=0, `inv_bit`=0, `vde_out`=0. Syncs are delayed by exactly 4 cycles.
- Reset mid-stream: stream a scanline, assert `reset` for 2 cycles -> outputs read reset values on the next edge, `hs_out`=`vs_out`=1. The first post-reset pixel appears 4 cycles after deassertion.
- Scanline sweep: drawX 0..639 at drawY=0 -> `vram_addr` sequence is 0 (16 cycles), 1 (16 cycles), ..., 39. `drawX_out` equals the input delayed by 4 cycles throughout.

Source files
------------

// File: rtl/text_fetch_pipeline_if.sv
// rtl/text_fetch_pipeline_if.sv - VRAM and font ROM read ports of the text fetch pipeline
interface text_fetch_pipeline_if;
  logic [10:0] vram_addr;
  logic [31:0] vram_rdata;
  logic [10:0] font_addr;
  logic [7:0]  font_data;

  modport master (
    output vram_addr,
    output font_addr,
    input  vram_rdata,
    input  font_data
  );

  modport slave (
    input  vram_addr,
    input  font_addr,
    output vram_rdata,
    output font_data
  );
endinterface

// File: rtl/text_fetch_pipeline.sv
// rtl/text_fetch_pipeline.sv - pixel-rate text cell fetch: VRAM word, font row and palette colours
// All outputs lag the sampled pixel by exactly four pixel_clk cycles.
module text_fetch_pipeline #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic                 pixel_clk,
  input  logic                 reset,
  input  logic [9:0]           drawX,
  input  logic [9:0]           drawY,
  input  logic                 hs,
  input  logic                 vs,
  input  logic                 vde,
  input  logic [255:0]         palette,
  text_fetch_pipeline_if.master mem,
  output logic [9:0]           drawX_out,
  output logic [9:0]           drawY_out,
  output logic                 hs_out,
  output logic                 vs_out,
  output logic                 vde_out,
  output logic                 inv_bit,
  output logic [31:0]          cmd,
  output logic [7:0]           font_line
);

  localparam logic [9:0] X_LIMIT = 10'(COLS * 8);
  localparam logic [9:0] Y_LIMIT = 10'(ROWS * 16);

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       vde;
  } side_t;

  // Syncs idle high so a flushed pipeline never emits a spurious sync pulse.
  localparam side_t SIDE_RST = '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, vde: 1'b0};

  side_t       side_a, side_1, side_b, side_c;
  logic        half_a, half_1;
  logic        inv_b, inv_c;
  logic [11:0] fg_b, bg_b, fg_c, bg_c;

  logic [6:0]  col;
  logic [4:0]  row;
  logic [11:0] idx;
  logic        in_range;
  logic [15:0] char_hw;

  function automatic logic [11:0] pal_color(input logic [255:0] pal, input logic [3:0] i);
    logic [7:0] base;
    base = {i[3:1], 5'd0} + (i[0] ? 8'd13 : 8'd1);
    return pal[base +: 12];
  endfunction

  assign col      = drawX[9:3];
  assign row      = drawY[8:4];
  assign idx      = {1'b0, row, 6'd0} + {3'd0, row, 4'd0} + {5'd0, col};
  assign in_range = (drawX < X_LIMIT) && (drawY < Y_LIMIT);
  assign char_hw  = half_1 ? mem.vram_rdata[31:16] : mem.vram_rdata[15:0];

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      mem.vram_addr <= '0;
      mem.font_addr <= '0;
      side_a        <= SIDE_RST;
      side_1        <= SIDE_RST;
      side_b        <= SIDE_RST;
      side_c        <= SIDE_RST;
      half_a        <= 1'b0;
      half_1        <= 1'b0;
      inv_b         <= 1'b0;
      inv_c         <= 1'b0;
      fg_b          <= '0;
      bg_b          <= '0;
      fg_c          <= '0;
      bg_c          <= '0;
      drawX_out     <= '0;
      drawY_out     <= '0;
      hs_out        <= 1'b1;
      vs_out        <= 1'b1;
      vde_out       <= 1'b0;
      inv_bit       <= 1'b0;
      cmd           <= '0;
      font_line     <= '0;
    end else begin
      // Stage A: row*80 is even, so idx[0] is the column parity (drawX[3]).
      mem.vram_addr <= in_range ? idx[11:1] : 11'd0;
      half_a        <= idx[0];
      side_a        <= '{x: drawX, y: drawY, hs: hs, vs: vs, vde: vde};

      // VRAM read cycle.
      half_1        <= half_a;
      side_1        <= side_a;

      // Stage B: decode the character and resolve colours.
      mem.font_addr <= {char_hw[14:8], side_1.y[3:0]};
      inv_b         <= char_hw[15];
      fg_b          <= pal_color(palette, char_hw[7:4]);
      bg_b          <= pal_color(palette, char_hw[3:0]);
      side_b        <= side_1;

      // Stage C: font ROM read cycle.
      inv_c         <= inv_b;
      fg_c          <= fg_b;
      bg_c          <= bg_b;
      side_c        <= side_b;

      // Output stage: blank everything outside active video.
      drawX_out     <= side_c.x;
      drawY_out     <= side_c.y;
      hs_out        <= side_c.hs;
      vs_out        <= side_c.vs;
      vde_out       <= side_c.vde;
      inv_bit       <= side_c.vde & inv_c;
      cmd           <= side_c.vde ? {7'd0, fg_c, bg_c, 1'b0} : 32'd0;
      font_line     <= side_c.vde ? mem.font_data : 8'd0;
    end
  end

endmodule

// File: tb/tb_text_fetch_pipeline.sv
// tb/tb_text_fetch_pipeline.sv - directed self-checking bench for text_fetch_pipeline
module tb_text_fetch_pipeline;

  logic         pixel_clk;
  logic         reset;
  logic [9:0]   drawX, drawY;
  logic         hs, vs, vde;
  logic [255:0] palette;
  logic [9:0]   drawX_out, drawY_out;
  logic         hs_out, vs_out, vde_out, inv_bit;
  logic [31:0]  cmd;
  logic [7:0]   font_line;

  logic [31:0]  vram [0:2047];
  int           n_cmp = 0;
  int           n_err = 0;
  int           hx [0:639];
  logic         bhs [0:13];
  logic         bvs [0:13];

  text_fetch_pipeline_if mem_if ();

  text_fetch_pipeline #(.COLS(80), .ROWS(30)) dut (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .drawX     (drawX),
    .drawY     (drawY),
    .hs        (hs),
    .vs        (vs),
    .vde       (vde),
    .palette   (palette),
    .mem       (mem_if.master),
    .drawX_out (drawX_out),
    .drawY_out (drawY_out),
    .hs_out    (hs_out),
    .vs_out    (vs_out),
    .vde_out   (vde_out),
    .inv_bit   (inv_bit),
    .cmd       (cmd),
    .font_line (font_line)
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  function automatic logic [7:0] font_rom(input logic [10:0] a);
    return a[7:0] ^ {a[10:8], 5'b10110};
  endfunction

  // One-cycle-latency VRAM and font ROM models.
  always @(posedge pixel_clk) begin
    mem_if.vram_rdata <= vram[mem_if.vram_addr];
    mem_if.font_data  <= font_rom(mem_if.font_addr);
  end

  function automatic logic [11:0] pcol(input logic [3:0] i);
    logic [31:0] wd;
    wd = palette[32 * int'(i[3:1]) +: 32];
    return i[0] ? wd[24:13] : wd[12:1];
  endfunction

  // Expected {inv_bit, cmd, font_line} for an in-range visible pixel.
  function automatic logic [40:0] model(input int x, input int y);
    int          idx;
    logic [31:0] w;
    logic [15:0] h;
    logic [10:0] fa;
    idx = (y / 16) * 80 + x / 8;
    w   = vram[idx / 2];
    h   = ((x / 8) % 2 == 1) ? w[31:16] : w[15:0];
    fa  = {h[14:8], 4'(y % 16)};
    return {h[15], 7'd0, pcol(h[7:4]), pcol(h[3:0]), 1'b0, font_rom(fa)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge pixel_clk);
  endtask

  task automatic drive(input int x, input int y, input logic h, input logic v, input logic e);
    drawX = 10'(x);
    drawY = 10'(y);
    hs    = h;
    vs    = v;
    vde   = e;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) vram[i] = 32'd0;
    vram[0]    = 32'h0000_4121;
    vram[40]   = 32'hC2F0_0000;
    vram[1199] = 32'h8A31_0000;
    for (int i = 1; i < 40; i++) vram[i] = 32'h9E37_79B9 * (i + 1);
    palette = '0;
    for (int k = 2; k < 7; k++) palette[32 * k +: 32] = 32'h0246_8ACE * k;
    palette[31:0]    = 32'h0123_4000;
    palette[63:32]   = 32'h0000_0ABC;
    palette[255:224] = 32'h0157_8000;

    reset = 1'b1;
    drive(0, 0, 1'b0, 1'b0, 1'b0);
    step(3);
    chk("rst_data", {vde_out, hs_out, vs_out, inv_bit, font_line, cmd}, {1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 32'd0});
    chk("rst_coord", {drawX_out, drawY_out}, 20'd0);
    chk("rst_addr", {mem_if.vram_addr, mem_if.font_addr}, 22'd0);

    // Cell 0
    reset = 1'b0;
    drive(0, 3, 1'b1, 1'b1, 1'b1);
    step(1);
    chk("c0_vram_addr", mem_if.vram_addr, 11'd0);
    step(2);
    chk("c0_font_addr", mem_if.font_addr, 11'h413);
    step(2);
    chk("c0_inv", inv_bit, 1'b0);
    chk("c0_cmd", cmd, 32'h00AB_D234);
    chk("c0_font", font_line, 8'h85);
    chk("c0_coord", {drawX_out, drawY_out, vde_out}, {10'd0, 10'd3, 1'b1});

    // Odd cell, high halfword
    drive(8, 16, 1'b1, 1'b1, 1'b1);
    step(1);
    chk("odd_vram_addr", mem_if.vram_addr, 11'd40);
    step(2);
    chk("odd_font_addr", mem_if.font_addr, 11'h420);
    step(2);
    chk("odd_out", {inv_bit, cmd, font_line}, {1'b1, 32'h0157_8000, 8'hB6});

    // Last visible cell
    drive(639, 479, 1'b1, 1'b1, 1'b1);
    step(1);
    chk("last_vram_addr", mem_if.vram_addr, 11'd1199);
    step(2);
    chk("last_font_addr", mem_if.font_addr, 11'h0AF);
    step(2);
    chk("last_out", {inv_bit, cmd, font_line}, {1'b1, 32'h0000_1234, 8'hB9});

    // Out-of-range positions fetch address 0
    drive(700, 10, 1'b1, 1'b1, 1'b0);
    step(1);
    chk("oor_x_addr", mem_if.vram_addr, 11'd0);
    drive(0, 500, 1'b1, 1'b1, 1'b0);
    step(1);
    chk("oor_y_addr", mem_if.vram_addr, 11'd0);

    // Blanking with syncs toggling; outputs lag stimulus by four edges
    for (int k = 0; k < 14; k++) begin
      bhs[k] = (k % 3 != 0);
      bvs[k] = (k % 4 != 0);
      drive(0, 3, bhs[k], bvs[k], k >= 10);
      step(1);
      if (k >= 4)
        chk($sformatf("blank_%0d", k - 4), {vde_out, hs_out, vs_out, inv_bit, font_line, cmd},
            {1'b0, bhs[k - 4], bvs[k - 4], 1'b0, 8'd0, 32'd0});
    end

    // Scanline sweep at drawY=0
    for (int k = 0; k < 640; k++) begin
      hx[k] = k;
      drive(k, 0, 1'b1, 1'b1, 1'b1);
      step(1);
      chk($sformatf("sweep_addr_%0d", k), mem_if.vram_addr, 11'(k / 16));
      if (k >= 4) begin
        chk($sformatf("sweep_x_%0d", k - 4), {drawX_out, vde_out}, {10'(hx[k - 4]), 1'b1});
        chk($sformatf("sweep_data_%0d", k - 4), {inv_bit, cmd, font_line}, model(hx[k - 4], 0));
      end
    end

    // Reset mid-stream
    for (int k = 0; k < 20; k++) begin
      drive(k, 0, 1'b0, 1'b0, 1'b1);
      step(1);
    end
    reset = 1'b1;
    step(1);
    chk("mrst_out", {vde_out, hs_out, vs_out, inv_bit, font_line, cmd, drawX_out},
        {1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 32'd0, 10'd0});
    chk("mrst_addr", {mem_if.vram_addr, mem_if.font_addr}, 22'd0);
    step(1);
    reset = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      drive(99 + j, 0, 1'b0, 1'b0, 1'b1);
      step(1);
      if (j < 5)
        chk($sformatf("mrst_flush_%0d", j), {vde_out, hs_out, vs_out}, 3'b011);
      else
        chk("mrst_first", {drawX_out, vde_out, hs_out, vs_out}, {10'd100, 1'b1, 1'b0, 1'b0});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
